tl_phase_ctrl: RTL and testbench

Traffic-light phase controller for a main-road/side-road intersection. Sequences the shared 8-bit down-counter timer (load/value/decr/timeup) through six light phases. Side phase is granted only on a latched side-road vehicle request. Sits between the sensor inputs and the lamp drivers; the timer is instantiated alongside it at top level.

---
 rtl/tl_pkg.sv | 35 +++
 rtl/tl_req_latch.sv | 33 +++
 rtl/tl_phase_ctrl.sv | 125 ++++++++++++
 tb/tb_tl_phase_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic-light phase controller.
package tl_pkg;

  localparam int unsigned TMR_W = 8;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRed1    = 3'd2,
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4,
    StAllRed2    = 3'd5
  } tl_state_e;

  function automatic logic [2:0] main_lamp(input tl_state_e s);
    case (s)
      StMainGreen:  main_lamp = LIGHT_GRN;
      StMainYellow: main_lamp = LIGHT_YEL;
      default:      main_lamp = LIGHT_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input tl_state_e s);
    case (s)
      StSideGreen:  side_lamp = LIGHT_GRN;
      StSideYellow: side_lamp = LIGHT_YEL;
      default:      side_lamp = LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_req_latch.sv
// Two-flop synchronizer feeding a sticky request latch; clear has priority over set.
module tl_req_latch (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  input  logic i_set_en,
  input  logic i_clr,
  output logic o_req
);

  logic r_sync1;
  logic r_sync2;
  logic r_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      if (i_clr) begin
        r_req <= 1'b0;
      end else if (i_set_en && r_sync2) begin
        r_req <= 1'b1;
      end
    end
  end

  assign o_req = r_req;

endmodule

// File: rtl/tl_phase_ctrl.sv
// Main/side intersection phase sequencer driving an external down-counter timer.
// Optional pedestrian crossing support is enabled with `define PED_XING_EN.
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter logic [TMR_W-1:0] GREEN_MAIN_T = 8'd30,
  parameter logic [TMR_W-1:0] YELLOW_T     = 8'd5,
  parameter logic [TMR_W-1:0] ALLRED_T     = 8'd2,
  parameter logic [TMR_W-1:0] GREEN_SIDE_T = 8'd20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             side_car,
  input  logic             tmr_timeup,
  output logic             tmr_load,
  output logic [TMR_W-1:0] tmr_value,
  output logic             tmr_decr,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light
`ifdef PED_XING_EN
  ,
  input  logic             ped_req,
  output logic             ped_walk
`endif
);

  tl_state_e  r_state;
  tl_state_e  w_state_d;
  logic       r_load_pending;
  logic [2:0] r_main_light;
  logic [2:0] r_side_light;
  logic       w_eval;
  logic       w_set_en;
  logic       w_enter_side;
  logic       w_side_req;
  logic       w_exit_req;

  // Timeup during the load cycle still reflects the previous phase's count.
  assign w_eval = ~r_load_pending & tmr_timeup;

  assign w_set_en = (r_state == StMainGreen) || (r_state == StMainYellow) ||
                    (r_state == StAllRed1)   || (r_state == StAllRed2);
  assign w_enter_side = (w_state_d == StSideGreen) && (r_state != StSideGreen);

  tl_req_latch u_side_req (
    .clk      (clk),
    .reset    (reset),
    .i_async  (side_car),
    .i_set_en (w_set_en),
    .i_clr    (w_enter_side),
    .o_req    (w_side_req)
  );

`ifdef PED_XING_EN
  logic w_ped_pend;
  logic r_ped_walk;

  tl_req_latch u_ped_req (
    .clk      (clk),
    .reset    (reset),
    .i_async  (ped_req),
    .i_set_en (w_set_en),
    .i_clr    (w_enter_side),
    .o_req    (w_ped_pend)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_walk <= 1'b0;
    end else if (w_enter_side) begin
      r_ped_walk <= w_ped_pend;
    end
  end

  assign w_exit_req = w_side_req | w_ped_pend;
  assign ped_walk   = r_ped_walk & (r_state == StSideGreen);
`else
  assign w_exit_req = w_side_req;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StMainGreen:  if (w_eval && w_exit_req) w_state_d = StMainYellow;
      StMainYellow: if (w_eval) w_state_d = StAllRed1;
      StAllRed1:    if (w_eval) w_state_d = StSideGreen;
      StSideGreen:  if (w_eval) w_state_d = StSideYellow;
      StSideYellow: if (w_eval) w_state_d = StAllRed2;
      StAllRed2:    if (w_eval) w_state_d = StMainGreen;
      default:      w_state_d = StAllRed2;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StAllRed2;
      r_load_pending <= 1'b1;
      r_main_light   <= LIGHT_RED;
      r_side_light   <= LIGHT_RED;
    end else begin
      r_state        <= w_state_d;
      r_load_pending <= (w_state_d != r_state);
      r_main_light   <= main_lamp(w_state_d);
      r_side_light   <= side_lamp(w_state_d);
    end
  end

  always_comb begin
    tmr_value = ALLRED_T;
    case (r_state)
      StMainGreen:  tmr_value = GREEN_MAIN_T;
      StMainYellow: tmr_value = YELLOW_T;
      StSideGreen:  tmr_value = GREEN_SIDE_T;
      StSideYellow: tmr_value = YELLOW_T;
      default:      tmr_value = ALLRED_T;
    endcase
  end

  assign tmr_load   = r_load_pending & ~reset;
  assign tmr_decr   = tick & ~r_load_pending & ~reset;
  assign main_light = r_main_light;
  assign side_light = r_side_light;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Scoreboard bench for tl_phase_ctrl with a behavioural timer and a phase-level reference model.
module tb_tl_phase_ctrl;

  localparam logic [7:0] T_GM = 8'd4;
  localparam logic [7:0] T_Y  = 8'd2;
  localparam logic [7:0] T_AR = 8'd1;
  localparam logic [7:0] T_GS = 8'd3;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       side_car;
  logic       ped_req;
  logic       tmr_timeup;
  logic       tmr_load;
  logic [7:0] tmr_value;
  logic       tmr_decr;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       ped_walk_obs;

  tl_phase_ctrl #(
    .GREEN_MAIN_T (T_GM),
    .YELLOW_T     (T_Y),
    .ALLRED_T     (T_AR),
    .GREEN_SIDE_T (T_GS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .side_car   (side_car),
    .tmr_timeup (tmr_timeup),
    .tmr_load   (tmr_load),
    .tmr_value  (tmr_value),
    .tmr_decr   (tmr_decr),
    .main_light (main_light),
    .side_light (side_light)
`ifdef PED_XING_EN
    ,
    .ped_req    (ped_req),
    .ped_walk   (ped_walk_obs)
`endif
  );

`ifndef PED_XING_EN
  assign ped_walk_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural saturating down-counter sharing the controller's reset.
  logic [7:0] tmr_cnt;
  always_ff @(posedge clk) begin
    if (reset)                        tmr_cnt <= 8'd0;
    else if (tmr_load)                tmr_cnt <= tmr_value;
    else if (tmr_decr && tmr_cnt != 0) tmr_cnt <= tmr_cnt - 8'd1;
  end
  assign tmr_timeup = (tmr_cnt == 8'd0);

  typedef struct {
    bit         load;
    bit         decr;
    logic [7:0] val;
    logic [2:0] ml;
    logic [2:0] sl;
    bit         walk;
    bit         chk;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: phase index 0..5 = main G, main Y, all-red 1, side G, side Y, all-red 2.
  int m_phase = 5;
  bit m_entry = 1'b1;
  int m_ticks = 0;
  bit m_req   = 1'b0;
  bit m_ped   = 1'b0;
  bit m_walk  = 1'b0;
  bit m_init  = 1'b0;
  bit car_h[2];
  bit ped_h[2];

  function automatic int dur(input int p);
    case (p)
      0:       return int'(T_GM);
      1, 4:    return int'(T_Y);
      3:       return int'(T_GS);
      default: return int'(T_AR);
    endcase
  endfunction

  function automatic logic [2:0] lamp(input int p, input int g, input int y);
    if (p == g) return 3'b001;
    if (p == y) return 3'b010;
    return 3'b100;
  endfunction

  task automatic model_step();
    exp_t e;
    int   nxt;
    bit   set_ok;
    bit   into_side;
    cyc++;
    e.cyc  = cyc;
    e.chk  = m_init;
    e.ml   = lamp(m_phase, 0, 1);
    e.sl   = lamp(m_phase, 3, 4);
    e.val  = 8'(dur(m_phase));
    e.walk = m_walk && (m_phase == 3);
    if (reset) begin
      e.load = 1'b0;
      e.decr = 1'b0;
      q.push_back(e);
      m_phase = 5; m_entry = 1'b1; m_ticks = 0;
      m_req = 1'b0; m_ped = 1'b0; m_walk = 1'b0; m_init = 1'b1;
      car_h[0] = 1'b0; car_h[1] = 1'b0; ped_h[0] = 1'b0; ped_h[1] = 1'b0;
    end else begin
      e.load = m_entry;
      e.decr = tick && !m_entry;
      q.push_back(e);
      nxt = m_phase;
      if (m_entry) begin
        m_entry = 1'b0;
        m_ticks = 0;
      end else if (m_ticks >= dur(m_phase)) begin
        if (m_phase != 0 || m_req || m_ped) nxt = (m_phase + 1) % 6;
      end else if (tick) begin
        m_ticks++;
      end
      set_ok    = (m_phase == 0) || (m_phase == 1) || (m_phase == 2) || (m_phase == 5);
      into_side = (nxt == 3) && (m_phase != 3);
      if (into_side) begin
`ifdef PED_XING_EN
        m_walk = m_ped;
`endif
        m_req = 1'b0;
        m_ped = 1'b0;
      end else begin
        if (set_ok && car_h[1]) m_req = 1'b1;
        if (set_ok && ped_h[1]) m_ped = 1'b1;
      end
      car_h[1] = car_h[0]; car_h[0] = side_car;
`ifdef PED_XING_EN
      ped_h[1] = ped_h[0]; ped_h[0] = ped_req;
`endif
      if (nxt != m_phase) begin
        m_phase = nxt;
        m_entry = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp, input int c);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, pop the prediction and compare.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("tmr_load", int'(tmr_load), int'(e.load), e.cyc);
      chk("tmr_decr", int'(tmr_decr), int'(e.decr), e.cyc);
      if (e.load) chk("tmr_value", int'(tmr_value), int'(e.val), e.cyc);
      if (e.chk) begin
        chk("main_light", int'(main_light), int'(e.ml), e.cyc);
        chk("side_light", int'(side_light), int'(e.sl), e.cyc);
        chk("lights_exclusive", int'(main_light != 3'b100 && side_light != 3'b100), 0, e.cyc);
`ifdef PED_XING_EN
        chk("ped_walk", int'(ped_walk_obs), int'(e.walk), e.cyc);
`endif
      end
    end
  end

  task automatic cycle(input bit rst, input bit tk, input bit car, input bit ped);
    @(posedge clk);
    #1;
    reset    = rst;
    tick     = tk;
    side_car = car;
    ped_req  = ped;
    model_step();
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n = 0;
    while (m_phase != p && n < budget) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    if (m_phase != p) begin
      total++;
      bad++;
      $display("FAIL wait_phase timeout phase=%0d expected=%0d", m_phase, p);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; tick = 1'b0; side_car = 1'b0; ped_req = 1'b0;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    // Idle road: green must hold with no reload.
    repeat (100) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    // One-cycle vehicle pulse drives a full side cycle.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    // Sensor held only while side green is lit must not be latched.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    wait_phase(3, 40);
    n = 0;
    while (m_phase == 3 && n < 20) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    repeat (40) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    // Reset in the middle of side green.
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    wait_phase(3, 40);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (30) cycle(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef PED_XING_EN
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (40) cycle(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    // Random ticks, sensors and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      cycle(bit'($urandom_range(0, 299) == 0), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 24) == 0), bit'($urandom_range(0, 39) == 0));
    end
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0, cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
